iot_data_filter: RTL and testbench
==================================

Name: iot_data_filter

Overview:
- Streaming IoT data filter.
- Receives 128-bit samples as 16 bytes, MSB byte first, and groups them into rounds of 8 samples.
- Emits filtered 128-bit results selected by fn_sel: round max, round min, round average, range extract, range exclude, peak-max or peak-min.
- Sits between a byte-serial sensor interface and a 128-bit result consumer.

Parameters:
- F4_LOW, 128'h6FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, exclusive lower bound for extract.
- F4_HIGH, 128'hAFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, exclusive upper bound for extract.
- F5_LOW, 128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, lower bound for exclude.
- F5_HIGH, 128'hBFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, upper bound for exclude.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- in_en  in  1  iot_in carries a valid byte this cycle.
- iot_in  in  8  data byte; byte 0 of a sample = bits [127:120].
- fn_sel  in  3  function select 1..7; static during operation.
- busy  out  1  1 = iot_in not accepted this cycle.
- valid  out  1  one-cycle pulse qualifying iot_out.
- iot_out  out  128  result value.

Behaviour:
- Reset (rst=0, asynchronous): busy=0, valid=0, iot_out=0; byte counter, sample counter, accumulators, round max/min and peak registers cleared; "first round" flag set.
- Input handshake:
  - A byte is accepted on a rising clk edge when in_en=1 and busy=0.
  - 16 accepted bytes shift in MSB-first to form one sample.
  - 8 samples form one round; the sample counter wraps 7->0.
  - Bytes with in_en=0 are ignored; counters hold.
- Output timing: valid=1 for exactly one cycle, on the cycle after the final qualifying byte is accepted; iot_out holds its value until the next valid.
- F1 (max): at round end, output the largest unsigned sample of the round.
- F2 (min): at round end, output the smallest unsigned sample of the round.
- F3 (avg):
  - Accumulate a 131-bit unsigned sum over the round.
  - Output floor(sum/8), i.e. sum[130:3].
  - Clear the sum for the next round.
- F4 (extract): after each sample completes, output it if F4_LOW < sample < F4_HIGH (strict); otherwise no valid.
- F5 (exclude): after each sample completes, output it if sample < F5_LOW or sample > F5_HIGH (strict); otherwise no valid.
- F6 (peak max):
  - At round end, compute the round max.
  - Output it and store it as peak if it is the first round or round max > stored peak (strict).
  - Equal or smaller: no output, peak unchanged.
- F7 (peak min): as F6 with round min and strict "<".
- Round max/min registers are reinitialised from the first sample of each round, not from 0 or all-ones.
- The first-round flag clears after round 1 ends.
- fn_sel changes are unsupported mid-stream; behaviour is only defined for a constant fn_sel from reset. fn_sel=0 is ignored: no valid ever.
- Reset mid-sample or mid-round discards the partial data; the next accepted byte is byte 0 of sample 0 of round 1.
- A sample completing on the same cycle as a round boundary produces at most one valid; F4/F5 outputs are per sample, and the others are per round.

Optional Feature:
- Macro IOTDF_BUSY_STALL_EN.
- Defined: busy=1 for exactly one cycle, the cycle after each round's 128th byte is accepted; input bytes are not accepted during it.
- Undefined: busy is constant 0 after reset.
- Results and valid sequence are identical in both builds; only input timing differs.

Test Plan:
- F1, round of samples 1..8 (128-bit values 1 to 8) -> one valid, iot_out=8.
- F2, round of 8, 3, 5, 9, 4, 7, 6, 2 -> iot_out=2. F3, same round -> sum 44, iot_out=5 (floor).
- F4, samples 128'h6FFF..FF, 128'h7000..00, 128'hAFFF..FF, 128'h8000..00 -> valid only for 7000..00 and 8000..00, in that order.
- F5, samples 128'h7FFF..FF, 128'h0, 128'hC000..00, 128'h9000..00 -> outputs 0 then C000..00 only.
- F6, three rounds with maxima 50, 40, 60 -> outputs 50 then 60 (two valids). F7 with minima 50, 40, 40 -> outputs 50 then 40 only.
- Reset asserted after 5 bytes of a sample, then a full F1 round of 1..8 -> iot_out=8, no stale data; busy/valid/iot_out read 0 during reset.

Source files
------------

// File: rtl/iot_data_filter.sv
// iot_data_filter
//   Streaming filter for byte-serial 128-bit IoT samples. Sixteen accepted
//   bytes (MSB byte first) form one sample and eight samples form one round.
//   fn_sel picks the result:
//     1 = round max
//     2 = round min
//     3 = round average
//     4 = range extract
//     5 = range exclude
//     6 = peak max
//     7 = peak min
//     0 = no output
//
// Build option:
//   IOTDF_BUSY_STALL_EN
//     Defined:   busy is raised for one cycle after each round's final byte.
//     Undefined: busy stays 0.
//
// Ports:
//   clk      in   1    system clock, rising edge
//   rst      in   1    asynchronous reset, active-low
//   in_en    in   1    iot_in carries a valid byte
//   iot_in   in   8    data byte
//   fn_sel   in   3    function select, static from reset
//   busy     out  1    1 = byte not accepted this cycle
//   valid    out  1    one-cycle pulse qualifying iot_out
//   iot_out  out  128  result, held until the next valid
//
// Stall FSM:
//   state   | meaning
//   S_RUN   | bytes accepted normally
//   S_STALL | one-cycle input stall after a round's last byte
module iot_data_filter #(
  parameter logic [127:0] F4_LOW  = 128'h6FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF,
  parameter logic [127:0] F4_HIGH = 128'hAFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF,
  parameter logic [127:0] F5_LOW  = 128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF,
  parameter logic [127:0] F5_HIGH = 128'hBFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_en,
  input  logic [7:0]   iot_in,
  input  logic [2:0]   fn_sel,
  output logic         busy,
  output logic         valid,
  output logic [127:0] iot_out
);

  typedef enum logic {S_RUN, S_STALL} state_t;

  state_t         state_q, state_d;
  logic [3:0]     byte_cnt_q;
  logic [2:0]     samp_cnt_q;
  logic [119:0]   shift_q;
  logic [130:0]   sum_q;
  logic [127:0]   rmax_q, rmin_q, peak_q;
  logic           first_round_q;

  logic           accept, sample_done, round_end, first_of_round;
  logic [127:0]   new_sample, cur_max, cur_min;
  logic [130:0]   sum_next;
  logic           fire;
  logic [127:0]   result;

  // Stall FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_RUN;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    case (state_q)
      S_RUN: begin
`ifdef IOTDF_BUSY_STALL_EN
        if (round_end) state_d = S_STALL;
`endif
      end
      S_STALL: begin
        busy    = 1'b1;
        state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  // Datapath combinational
  assign accept         = in_en && !busy;
  assign sample_done    = accept && (byte_cnt_q == 4'd15);
  assign round_end      = sample_done && (samp_cnt_q == 3'd7);
  assign first_of_round = (samp_cnt_q == 3'd0);
  // The last byte is merged directly so the sample is usable on the
  // accepting edge itself.
  assign new_sample     = {shift_q, iot_in};

  // Round extremes restart from the first sample of the round, not from a
  // fixed 0 / all-ones seed.
  assign cur_max  = (first_of_round || (new_sample > rmax_q)) ? new_sample : rmax_q;
  assign cur_min  = (first_of_round || (new_sample < rmin_q)) ? new_sample : rmin_q;
  assign sum_next = sum_q + {3'b000, new_sample};

  always_comb begin
    fire   = 1'b0;
    result = '0;
    case (fn_sel)
      3'd1: begin
        fire   = round_end;
        result = cur_max;
      end
      3'd2: begin
        fire   = round_end;
        result = cur_min;
      end
      3'd3: begin
        fire   = round_end;
        result = sum_next[130:3];
      end
      3'd4: begin
        fire   = sample_done && (new_sample > F4_LOW) && (new_sample < F4_HIGH);
        result = new_sample;
      end
      3'd5: begin
        fire   = sample_done && ((new_sample < F5_LOW) || (new_sample > F5_HIGH));
        result = new_sample;
      end
      3'd6: begin
        fire   = round_end && (first_round_q || (cur_max > peak_q));
        result = cur_max;
      end
      3'd7: begin
        fire   = round_end && (first_round_q || (cur_min < peak_q));
        result = cur_min;
      end
      default: begin
        fire   = 1'b0;
        result = '0;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_cnt_q    <= '0;
      samp_cnt_q    <= '0;
      shift_q       <= '0;
      sum_q         <= '0;
      rmax_q        <= '0;
      rmin_q        <= '0;
      peak_q        <= '0;
      first_round_q <= 1'b1;
      valid         <= 1'b0;
      iot_out       <= '0;
    end else begin
      valid <= fire;
      if (fire) iot_out <= result;

      if (accept) begin
        byte_cnt_q <= byte_cnt_q + 4'd1;
        shift_q    <= {shift_q[111:0], iot_in};
      end

      if (sample_done) begin
        samp_cnt_q <= samp_cnt_q + 3'd1;
        rmax_q     <= cur_max;
        rmin_q     <= cur_min;
        sum_q      <= round_end ? '0 : sum_next;
      end

      if (round_end) first_round_q <= 1'b0;

      // The peak register is shared by F6/F7; only the active function
      // ever fires, since fn_sel is fixed from reset.
      if (fire && (fn_sel == 3'd6 || fn_sel == 3'd7)) peak_q <= result;
    end
  end

endmodule

// File: tb/tb_iot_data_filter.sv
// Directed testbench for iot_data_filter.
module tb_iot_data_filter;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_en;
  logic [7:0]   iot_in;
  logic [2:0]   fn_sel;
  logic         busy;
  logic         valid;
  logic [127:0] iot_out;

  int n_tests = 0;
  int n_fail  = 0;

  logic [127:0] cap_q[$];
  logic [127:0] rbuf[8];

  iot_data_filter dut (
    .clk    (clk),
    .rst    (rst),
    .in_en  (in_en),
    .iot_in (iot_in),
    .fn_sel (fn_sel),
    .busy   (busy),
    .valid  (valid),
    .iot_out(iot_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst && valid) cap_q.push_back(iot_out);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic apply_reset(input logic [2:0] fn);
    in_en  = 1'b0;
    iot_in = 8'h00;
    fn_sel = fn;
    rst    = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    cap_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 8) begin
      guard++;
      @(negedge clk);
    end
    if (busy) begin
      n_tests++;
      n_fail++;
      $display("FAIL busy_timeout: busy=%0b want 0", busy);
    end
    in_en  = 1'b1;
    iot_in = b;
    @(posedge clk);
    #1;
    in_en = 1'b0;
  endtask

  task automatic send_sample(input logic [127:0] v);
    for (int i = 0; i < 16; i++) send_byte(v[127 - 8*i -: 8]);
  endtask

  task automatic send_round();
    for (int i = 0; i < 8; i++) send_sample(rbuf[i]);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst    = 1'b0;
    in_en  = 1'b0;
    iot_in = 8'h00;
    fn_sel = 3'd1;
    #1;
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_tests++;
    if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", valid); end
    n_tests++;
    if (iot_out !== 128'd0) begin n_fail++; $display("FAIL reset_iot_out: got %h want 0", iot_out); end
    apply_reset(3'd1);
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy: got %0b want 0", busy); end
  endtask

  task automatic test_f1_max();
    apply_reset(3'd1);
    for (int i = 0; i < 8; i++) rbuf[i] = 128'(i + 1);
    send_round();
    n_tests++;
    if (cap_q.size() != 1) begin
      n_fail++; $display("FAIL f1_count: got %0d want 1", cap_q.size());
    end else begin
      n_tests++;
      if (cap_q[0] !== 128'd8) begin n_fail++; $display("FAIL f1_value: got %h want 8", cap_q[0]); end
    end
  endtask

  task automatic test_f2_min();
    apply_reset(3'd2);
    rbuf = '{128'd8, 128'd3, 128'd5, 128'd9, 128'd4, 128'd7, 128'd6, 128'd2};
    send_round();
    n_tests++;
    if (cap_q.size() != 1) begin
      n_fail++; $display("FAIL f2_count: got %0d want 1", cap_q.size());
    end else begin
      n_tests++;
      if (cap_q[0] !== 128'd2) begin n_fail++; $display("FAIL f2_value: got %h want 2", cap_q[0]); end
    end
  endtask

  task automatic test_f3_avg();
    apply_reset(3'd3);
    rbuf = '{128'd8, 128'd3, 128'd5, 128'd9, 128'd4, 128'd7, 128'd6, 128'd2};
    send_round();
    // second round: sum must restart from zero (8*16=128 -> 16)
    for (int i = 0; i < 8; i++) rbuf[i] = 128'd16;
    send_round();
    n_tests++;
    if (cap_q.size() != 2) begin
      n_fail++; $display("FAIL f3_count: got %0d want 2", cap_q.size());
    end else begin
      n_tests++;
      if (cap_q[0] !== 128'd5) begin n_fail++; $display("FAIL f3_avg1: got %h want 5", cap_q[0]); end
      n_tests++;
      if (cap_q[1] !== 128'd16) begin n_fail++; $display("FAIL f3_avg2: got %h want 10", cap_q[1]); end
    end
  endtask

  task automatic test_f4_extract();
    apply_reset(3'd4);
    send_sample(128'h6FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF);
    send_sample(128'h7000_0000_0000_0000_0000_0000_0000_0000);
    send_sample(128'hAFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF);
    send_sample(128'h8000_0000_0000_0000_0000_0000_0000_0000);
    repeat (3) @(negedge clk);
    n_tests++;
    if (cap_q.size() != 2) begin
      n_fail++; $display("FAIL f4_count: got %0d want 2", cap_q.size());
    end else begin
      n_tests++;
      if (cap_q[0] !== 128'h7000_0000_0000_0000_0000_0000_0000_0000) begin
        n_fail++; $display("FAIL f4_first: got %h want 7000..00", cap_q[0]);
      end
      n_tests++;
      if (cap_q[1] !== 128'h8000_0000_0000_0000_0000_0000_0000_0000) begin
        n_fail++; $display("FAIL f4_second: got %h want 8000..00", cap_q[1]);
      end
    end
  endtask

  task automatic test_f5_exclude();
    apply_reset(3'd5);
    send_sample(128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF);
    send_sample(128'h0);
    send_sample(128'hC000_0000_0000_0000_0000_0000_0000_0000);
    send_sample(128'h9000_0000_0000_0000_0000_0000_0000_0000);
    send_sample(128'hBFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF);
    repeat (3) @(negedge clk);
    n_tests++;
    if (cap_q.size() != 2) begin
      n_fail++; $display("FAIL f5_count: got %0d want 2", cap_q.size());
    end else begin
      n_tests++;
      if (cap_q[0] !== 128'h0) begin n_fail++; $display("FAIL f5_first: got %h want 0", cap_q[0]); end
      n_tests++;
      if (cap_q[1] !== 128'hC000_0000_0000_0000_0000_0000_0000_0000) begin
        n_fail++; $display("FAIL f5_second: got %h want C000..00", cap_q[1]);
      end
    end
  endtask

  task automatic test_f6_peak_max();
    apply_reset(3'd6);
    rbuf = '{128'd10, 128'd20, 128'd50, 128'd5, 128'd1, 128'd2, 128'd3, 128'd4};
    send_round();
    rbuf = '{128'd40, 128'd1, 128'd2, 128'd3, 128'd4, 128'd5, 128'd6, 128'd7};
    send_round();
    rbuf = '{128'd1, 128'd2, 128'd3, 128'd4, 128'd5, 128'd6, 128'd7, 128'd60};
    send_round();
    n_tests++;
    if (cap_q.size() != 2) begin
      n_fail++; $display("FAIL f6_count: got %0d want 2", cap_q.size());
    end else begin
      n_tests++;
      if (cap_q[0] !== 128'd50) begin n_fail++; $display("FAIL f6_first: got %h want 32", cap_q[0]); end
      n_tests++;
      if (cap_q[1] !== 128'd60) begin n_fail++; $display("FAIL f6_second: got %h want 3c", cap_q[1]); end
    end
  endtask

  task automatic test_f7_peak_min();
    apply_reset(3'd7);
    rbuf = '{128'd100, 128'd90, 128'd50, 128'd70, 128'd80, 128'd99, 128'd77, 128'd66};
    send_round();
    rbuf = '{128'd80, 128'd40, 128'd60, 128'd61, 128'd62, 128'd63, 128'd64, 128'd65};
    send_round();
    rbuf = '{128'd40, 128'd99, 128'd98, 128'd97, 128'd96, 128'd95, 128'd94, 128'd93};
    send_round();
    n_tests++;
    if (cap_q.size() != 2) begin
      n_fail++; $display("FAIL f7_count: got %0d want 2", cap_q.size());
    end else begin
      n_tests++;
      if (cap_q[0] !== 128'd50) begin n_fail++; $display("FAIL f7_first: got %h want 32", cap_q[0]); end
      n_tests++;
      if (cap_q[1] !== 128'd40) begin n_fail++; $display("FAIL f7_second: got %h want 28", cap_q[1]); end
    end
  endtask

  task automatic test_fn0_silent();
    apply_reset(3'd0);
    for (int i = 0; i < 8; i++) rbuf[i] = 128'(i + 3);
    send_round();
    n_tests++;
    if (cap_q.size() != 0) begin n_fail++; $display("FAIL fn0_count: got %0d want 0", cap_q.size()); end
  endtask

  task automatic test_mid_reset();
    apply_reset(3'd1);
    for (int i = 0; i < 8; i++) rbuf[i] = 128'(100 + i);
    send_round();
    for (int i = 0; i < 5; i++) send_byte(8'hAB);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %0b want 0", busy); end
    n_tests++;
    if (valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %0b want 0", valid); end
    n_tests++;
    if (iot_out !== 128'd0) begin n_fail++; $display("FAIL midrst_iot_out: got %h want 0", iot_out); end
    @(negedge clk);
    rst = 1'b1;
    cap_q.delete();
    for (int i = 0; i < 8; i++) rbuf[i] = 128'(i + 1);
    send_round();
    n_tests++;
    if (cap_q.size() != 1) begin
      n_fail++; $display("FAIL midrst_count: got %0d want 1", cap_q.size());
    end else begin
      n_tests++;
      if (cap_q[0] !== 128'd8) begin n_fail++; $display("FAIL midrst_value: got %h want 8", cap_q[0]); end
    end
    repeat (5) @(negedge clk);
    n_tests++;
    if (iot_out !== 128'd8) begin n_fail++; $display("FAIL hold_iot_out: got %h want 8", iot_out); end
  endtask

  task automatic test_back_to_back();
    apply_reset(3'd1);
    for (int i = 0; i < 8; i++) rbuf[i] = 128'(i + 1);
    for (int i = 0; i < 8; i++) send_sample(rbuf[i]);
    for (int i = 0; i < 8; i++) rbuf[i] = 128'(16 - i);
    for (int i = 0; i < 8; i++) send_sample(rbuf[i]);
    repeat (3) @(negedge clk);
    n_tests++;
    if (cap_q.size() != 2) begin
      n_fail++; $display("FAIL b2b_count: got %0d want 2", cap_q.size());
    end else begin
      n_tests++;
      if (cap_q[0] !== 128'd8) begin n_fail++; $display("FAIL b2b_first: got %h want 8", cap_q[0]); end
      n_tests++;
      if (cap_q[1] !== 128'd16) begin n_fail++; $display("FAIL b2b_second: got %h want 10", cap_q[1]); end
    end
  endtask

  initial begin
    test_reset();
    test_f1_max();
    test_f2_min();
    test_f3_avg();
    test_f4_extract();
    test_f5_exclude();
    test_f6_peak_max();
    test_f7_peak_min();
    test_fn0_silent();
    test_mid_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
